// File: rtl/swc_pkg.sv
// Shared switch-core sizes: free-pointer pool, cell geometry and companion RAM dimensions.
// Also holds the free-queue state type used by multi_user_free_queue.
package swc_pkg;

    localparam int PTR_W     = 10;
    localparam int DEPTH     = 512;
    localparam int CNT_W     = 10;
    localparam int ADDR_W    = $clog2(DEPTH);
    localparam int PTR_DIN_W = 16;

    localparam int BEAT_W     = 128;
    localparam int CELL_BEATS = 4;
    localparam int CELL_BYTES = CELL_BEATS * BEAT_W / 8;

    localparam int DATA_RAM_W     = 128;
    localparam int DATA_RAM_DEPTH = 2048;
    localparam int DATA_RAM_AW    = $clog2(DATA_RAM_DEPTH);
    localparam int MC_RAM_W       = 4;
    localparam int MC_RAM_DEPTH   = 512;
    localparam int MC_RAM_AW      = $clog2(MC_RAM_DEPTH);

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef enum logic {
        FQ_INIT,
        FQ_RUN
    } fq_state_t;

endpackage

// File: rtl/fq_ptr_mem.sv
// Free-pointer storage: one synchronous write port, one asynchronous (show-ahead) read port.
module fq_ptr_mem #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int ENTRIES = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [ENTRIES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/multi_user_free_queue.sv
// Free-pointer manager for the shared cell buffer; self-fills with 0..DEPTH-1 after reset.
// Optional sticky fq_underflow/fq_overflow outputs are built when FQ_ERR_FLAGS_EN is defined.
module multi_user_free_queue
    import swc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [PTR_DIN_W-1:0] ptr_din,
    input  logic                 FQ_wr,
    input  logic                 FQ_rd,
    output logic [PTR_W-1:0]     ptr_dout_s,
    output logic                 ptr_fifo_empty,
    output logic                 FQ_act,
    output logic [CNT_W-1:0]     FQ_count
`ifdef FQ_ERR_FLAGS_EN
    ,
    output logic                 fq_underflow,
    output logic                 fq_overflow
`endif
);

    fq_state_t         state;
    fq_state_t         next_state;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [CNT_W-1:0]  init_cnt;
    logic              init_wr;
    logic              do_pop;
    logic              do_push;
    logic              mem_we;
    logic [PTR_W-1:0]  mem_wdata;
    logic [PTR_W-1:0]  mem_rdata;
    logic              unused_din_bits;

    // Upper pointer bits are reserved by the caller and carry no meaning here.
    assign unused_din_bits = ^ptr_din[PTR_DIN_W-1:PTR_W];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= FQ_INIT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            FQ_INIT: if (init_cnt == FULL_COUNT) next_state = FQ_RUN;
            FQ_RUN:  next_state = FQ_RUN;
            default: next_state = FQ_INIT;
        endcase
    end

    // Strobes are only honoured in RUN; INIT owns the write port until the pool is full.
    always_comb begin
        FQ_act  = 1'b0;
        init_wr = 1'b0;
        do_pop  = 1'b0;
        do_push = 1'b0;
        case (state)
            FQ_INIT: init_wr = (init_cnt != FULL_COUNT);
            FQ_RUN: begin
                FQ_act  = 1'b1;
                do_pop  = FQ_rd && !ptr_fifo_empty;
                do_push = FQ_wr && (FQ_count != FULL_COUNT);
            end
            default: ;
        endcase
        mem_we    = init_wr || do_push;
        mem_wdata = init_wr ? init_cnt[PTR_W-1:0] : ptr_din[PTR_W-1:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            init_cnt <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            FQ_count <= '0;
        end else if (init_wr) begin
            init_cnt <= init_cnt + CNT_W'(1);
            wr_ptr   <= wr_ptr + ADDR_W'(1);
            FQ_count <= FQ_count + CNT_W'(1);
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({do_push, do_pop})
                2'b10:   FQ_count <= FQ_count + CNT_W'(1);
                2'b01:   FQ_count <= FQ_count - CNT_W'(1);
                default: FQ_count <= FQ_count;
            endcase
        end
    end

    fq_ptr_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (PTR_W)
    ) u_ptr_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr),
        .wdata (mem_wdata),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    // Head reads as zero while empty so the output is defined straight out of reset.
    assign ptr_fifo_empty = (FQ_count == '0);
    assign ptr_dout_s     = ptr_fifo_empty ? '0 : mem_rdata;

`ifdef FQ_ERR_FLAGS_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fq_underflow <= 1'b0;
            fq_overflow  <= 1'b0;
        end else if (state == FQ_INIT) begin
            if (FQ_rd) fq_underflow <= 1'b1;
            if (FQ_wr) fq_overflow  <= 1'b1;
        end else begin
            if (FQ_rd && ptr_fifo_empty)           fq_underflow <= 1'b1;
            if (FQ_wr && (FQ_count == FULL_COUNT)) fq_overflow  <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_multi_user_free_queue.sv
// Randomised self-checking bench for multi_user_free_queue against a queue-based pool model.
// Define FQ_ERR_FLAGS_EN to also check the sticky error flags.
module tb_multi_user_free_queue;
    import swc_pkg::*;

    logic                 clk;
    logic                 rstn;
    logic [PTR_DIN_W-1:0] ptr_din;
    logic                 FQ_wr;
    logic                 FQ_rd;
    logic [PTR_W-1:0]     ptr_dout_s;
    logic                 ptr_fifo_empty;
    logic                 FQ_act;
    logic [CNT_W-1:0]     FQ_count;
`ifdef FQ_ERR_FLAGS_EN
    logic                 fq_underflow;
    logic                 fq_overflow;
`endif

    int total;
    int bad;
    int fq[$];
    int init_edges;
    bit act_m;
    bit uf_m;
    bit of_m;

    multi_user_free_queue dut (
        .clk            (clk),
        .rstn           (rstn),
        .ptr_din        (ptr_din),
        .FQ_wr          (FQ_wr),
        .FQ_rd          (FQ_rd),
        .ptr_dout_s     (ptr_dout_s),
        .ptr_fifo_empty (ptr_fifo_empty),
        .FQ_act         (FQ_act),
        .FQ_count       (FQ_count)
`ifdef FQ_ERR_FLAGS_EN
        ,
        .fq_underflow   (fq_underflow),
        .fq_overflow    (fq_overflow)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function void modelReset();
        fq.delete();
        init_edges = 0;
        act_m = 1'b0;
        uf_m  = 1'b0;
        of_m  = 1'b0;
    endfunction

    // One clock edge of the pool: fill one entry per edge, then one edge to go active.
    function void modelStep();
        bit pop_ok;
        bit push_ok;
        if (!act_m) begin
            if (FQ_rd) uf_m = 1'b1;
            if (FQ_wr) of_m = 1'b1;
            if (init_edges < DEPTH) fq.push_back(init_edges);
            else act_m = 1'b1;
            init_edges++;
        end else begin
            pop_ok  = FQ_rd && (fq.size() > 0);
            push_ok = FQ_wr && (fq.size() < DEPTH);
            if (FQ_rd && !pop_ok)  uf_m = 1'b1;
            if (FQ_wr && !push_ok) of_m = 1'b1;
            if (pop_ok)  void'(fq.pop_front());
            if (push_ok) fq.push_back(int'(ptr_din[PTR_W-1:0]));
        end
    endfunction

    task automatic applyStimulus(input bit rd, input bit wr, input logic [PTR_DIN_W-1:0] din);
        FQ_rd   = rd;
        FQ_wr   = wr;
        ptr_din = din;
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic waitForAct(input bit noisy);
        int n;
        n = 0;
        while (!FQ_act && n < 1000) begin
            if (noisy) applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
            else       applyStimulus(1'b0, 1'b0, '0);
            n++;
        end
        checkOutput("init_edges", n, DEPTH + 1);
        FQ_rd = 1'b0;
        FQ_wr = 1'b0;
    endtask

    always @(negedge clk) begin
        checkOutput("act", int'(FQ_act), int'(act_m));
        checkOutput("count", int'(FQ_count), fq.size());
        checkOutput("empty", int'(ptr_fifo_empty), int'(fq.size() == 0));
        if (fq.size() > 0) checkOutput("head", int'(ptr_dout_s), fq[0]);
`ifdef FQ_ERR_FLAGS_EN
        checkOutput("underflow", int'(fq_underflow), int'(uf_m));
        checkOutput("overflow", int'(fq_overflow), int'(of_m));
`endif
    end

    initial begin
        int captured;
        int expect_head;
        int n;
        total   = 0;
        bad     = 0;
        rstn    = 1'b0;
        FQ_rd   = 1'b0;
        FQ_wr   = 1'b0;
        ptr_din = '0;
        modelReset();

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_act", int'(FQ_act), 0);
        checkOutput("rst_count", int'(FQ_count), 0);
        checkOutput("rst_empty", int'(ptr_fifo_empty), 1);
        checkOutput("rst_dout", int'(ptr_dout_s), 0);

        $display("[TB] releasing reset, waiting for init");
        rstn = 1'b1;
        waitForAct(1'b0);
        checkOutput("init_count", int'(FQ_count), 512);
        checkOutput("init_empty", int'(ptr_fifo_empty), 0);
        checkOutput("init_dout", int'(ptr_dout_s), 0);

        for (int i = 0; i < 3; i++) begin
            captured = int'(ptr_dout_s);
            checkOutput($sformatf("pop_head%0d", i), captured, i);
            applyStimulus(1'b1, 1'b0, '0);
            applyStimulus(1'b0, 1'b0, '0);
        end
        checkOutput("pop3_count", int'(FQ_count), 509);
        checkOutput("pop3_dout", int'(ptr_dout_s), 3);

        repeat (509) applyStimulus(1'b1, 1'b0, '0);
        checkOutput("drain_empty", int'(ptr_fifo_empty), 1);
        checkOutput("drain_count", int'(FQ_count), 0);
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("underrun_count", int'(FQ_count), 0);
        checkOutput("underrun_empty", int'(ptr_fifo_empty), 1);
`ifdef FQ_ERR_FLAGS_EN
        checkOutput("underrun_flag", int'(fq_underflow), 1);
`endif

        applyStimulus(1'b0, 1'b1, 16'hC07B);
        checkOutput("push_dout", int'(ptr_dout_s), 'h07B);
        checkOutput("push_empty", int'(ptr_fifo_empty), 0);
        checkOutput("push_count", int'(FQ_count), 1);

        for (int i = 0; i < 99; i++) applyStimulus(1'b0, 1'b1, 16'(200 + i));
        checkOutput("c100_count", int'(FQ_count), 100);
        checkOutput("c100_dout", int'(ptr_dout_s), 'h07B);
        applyStimulus(1'b1, 1'b1, 16'd5);
        checkOutput("rdwr_count", int'(FQ_count), 100);
        checkOutput("rdwr_dout", int'(ptr_dout_s), 200);
        repeat (99) applyStimulus(1'b1, 1'b0, '0);
        checkOutput("tail_dout", int'(ptr_dout_s), 5);
        checkOutput("tail_count", int'(FQ_count), 1);

        $display("[TB] random traffic");
        repeat (800) applyStimulus($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 8, 16'($urandom));
        repeat (800) applyStimulus($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3, 16'($urandom));
        repeat (400) applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));

        n = 0;
        while (fq.size() < DEPTH && n < 1000) begin
            applyStimulus(1'b0, 1'b1, 16'($urandom));
            n++;
        end
        checkOutput("full_count", int'(FQ_count), 512);
        expect_head = fq[0];
        applyStimulus(1'b0, 1'b1, 16'h0155);
        checkOutput("overrun_count", int'(FQ_count), 512);
        checkOutput("overrun_head", int'(ptr_dout_s), expect_head);
`ifdef FQ_ERR_FLAGS_EN
        checkOutput("overrun_flag", int'(fq_overflow), 1);
`endif

        $display("[TB] mid-run reset");
        #2;
        rstn = 1'b0;
        modelReset();
        #1;
        checkOutput("mid_rst_act", int'(FQ_act), 0);
        checkOutput("mid_rst_count", int'(FQ_count), 0);
        checkOutput("mid_rst_empty", int'(ptr_fifo_empty), 1);
        checkOutput("mid_rst_dout", int'(ptr_dout_s), 0);
`ifdef FQ_ERR_FLAGS_EN
        checkOutput("mid_rst_uf", int'(fq_underflow), 0);
        checkOutput("mid_rst_of", int'(fq_overflow), 0);
`endif
        rstn = 1'b1;
        waitForAct(1'b1);
        checkOutput("reinit_count", int'(FQ_count), 512);
        checkOutput("reinit_dout", int'(ptr_dout_s), 0);
        checkOutput("reinit_empty", int'(ptr_fifo_empty), 0);

        repeat (200) applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
        applyStimulus(1'b0, 1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
